// File: rtl/prim_clock_gate_ctrl_pkg.sv
// Shared types, counter widths and parameter checks for the clock-gate controller.
// Used by prim_clock_gate_ctrl and prim_cg_sat_counter.
package prim_clock_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_GATED  = 2'd1,
        ST_WAKE   = 2'd2
    } state_e;

    localparam int IDLE_CNT_W = 8;
    localparam int WAKE_CNT_W = 4;

    localparam int IDLE_CYCLES_MIN = 1;
    localparam int IDLE_CYCLES_MAX = (1 << IDLE_CNT_W) - 1;
    localparam int WAKE_CYCLES_MIN = 1;
    localparam int WAKE_CYCLES_MAX = (1 << WAKE_CNT_W) - 1;

    function automatic bit params_legal(int idle_cycles, int wake_cycles, int stats_width);
        return (idle_cycles >= IDLE_CYCLES_MIN) && (idle_cycles <= IDLE_CYCLES_MAX) &&
               (wake_cycles >= WAKE_CYCLES_MIN) && (wake_cycles <= WAKE_CYCLES_MAX) &&
               (stats_width >= 1);
    endfunction

    // Terminal count is cycles-1; out-of-range values are clamped so the build stays well formed.
    function automatic logic [IDLE_CNT_W-1:0] idle_terminal(int idle_cycles);
        int v;
        v = idle_cycles;
        if (v < IDLE_CYCLES_MIN) v = IDLE_CYCLES_MIN;
        if (v > IDLE_CYCLES_MAX) v = IDLE_CYCLES_MAX;
        return IDLE_CNT_W'(v - 1);
    endfunction

    function automatic logic [WAKE_CNT_W-1:0] wake_terminal(int wake_cycles);
        int v;
        v = wake_cycles;
        if (v < WAKE_CYCLES_MIN) v = WAKE_CYCLES_MIN;
        if (v > WAKE_CYCLES_MAX) v = WAKE_CYCLES_MAX;
        return WAKE_CNT_W'(v - 1);
    endfunction

endpackage

// File: rtl/prim_cg_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Holds at all-ones rather than wrapping.
module prim_cg_sat_counter #(
    parameter int               Width    = 8,
    parameter logic [Width-1:0] Terminal = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [Width-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == Terminal);

endmodule

// File: rtl/prim_clock_gate_ctrl.sv
// Idle-driven clock-gate controller: gates after IdleCycles idle cycles, wakes on busy/request.
// Define PRIM_CLOCK_GATE_CTRL_STATS_EN to add the gated_cycles_o statistics counter.
module prim_clock_gate_ctrl
    import prim_clock_gate_ctrl_pkg::*;
#(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2,
    parameter int StatsWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    input  logic                  test_en_i,
    output logic                  en_o,
    output logic                  gated_o,
    output logic                  wake_ack_o
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    ,
    output logic [StatsWidth-1:0] gated_cycles_o
`endif
);

    localparam bit                   ParamsLegal = params_legal(IdleCycles, WakeCycles, StatsWidth);
    localparam logic [IDLE_CNT_W-1:0] IdleTc     = idle_terminal(IdleCycles);
    localparam logic [WAKE_CNT_W-1:0] WakeTc     = wake_terminal(WakeCycles);

    state_e state_q;
    logic   en_q;
    logic   gated_q;
    logic   wake_ack_q;
    logic   req_seen_q;

    logic idle;
    logic go_gate;
    logic idle_clr;
    logic idle_inc;
    logic idle_tc;
    logic wake_clr;
    logic wake_inc;
    logic wake_tc;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        idle     = 1'b0;
        go_gate  = 1'b0;
        idle_clr = 1'b1;
        idle_inc = 1'b0;
        wake_clr = 1'b1;
        wake_inc = 1'b0;

        idle = !busy_i && !wake_req_i;
        if (state_q == ST_ACTIVE) begin
            go_gate  = idle && idle_tc;
            idle_inc = idle;
            idle_clr = test_en_i || !idle || go_gate;
        end
        if (state_q == ST_WAKE) begin
            wake_inc = 1'b1;
            wake_clr = test_en_i;
        end
    end

    prim_cg_sat_counter #(
        .Width    (IDLE_CNT_W),
        .Terminal (IdleTc)
    ) u_idle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (idle_clr),
        .inc_i (idle_inc),
        .tc_o  (idle_tc)
    );

    prim_cg_sat_counter #(
        .Width    (WAKE_CNT_W),
        .Terminal (WakeTc)
    ) u_wake_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (wake_clr),
        .inc_i (wake_inc),
        .tc_o  (wake_tc)
    );

    // Reset and test override both land in ACTIVE with the clock enabled and no pending ack.
    always_ff @(posedge clk_i) begin
        if (rst_i || test_en_i) begin
            state_q    <= ST_ACTIVE;
            en_q       <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
            req_seen_q <= 1'b0;
        end else begin
            wake_ack_q <= 1'b0;
            case (state_q)
                ST_ACTIVE: begin
                    if (go_gate) begin
                        state_q <= ST_GATED;
                        en_q    <= 1'b0;
                        gated_q <= 1'b1;
                    end else begin
                        wake_ack_q <= wake_req_i && !wake_ack_q;
                    end
                end
                ST_GATED: begin
                    if (busy_i || wake_req_i) begin
                        state_q    <= ST_WAKE;
                        en_q       <= 1'b1;
                        gated_q    <= 1'b0;
                        req_seen_q <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (wake_req_i) begin
                        req_seen_q <= 1'b1;
                    end
                    // Ack only a request that was actually pending during the wake window.
                    if (wake_tc) begin
                        state_q    <= ST_ACTIVE;
                        wake_ack_q <= (req_seen_q || wake_req_i) && !wake_ack_q;
                        req_seen_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACTIVE;
                    en_q    <= 1'b1;
                    gated_q <= 1'b0;
                end
            endcase
        end
    end

    assign en_o       = en_q | test_en_i;
    assign gated_o    = gated_q & ~test_en_i;
    assign wake_ack_o = wake_ack_q;

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    logic [StatsWidth-1:0] gated_cycles_q;

    // Free-running statistic: wraps modulo 2^StatsWidth by design.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_cycles_q <= '0;
        end else if (state_q == ST_GATED) begin
            gated_cycles_q <= gated_cycles_q + 1'b1;
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`endif

    params_legal_a: assert property (@(posedge clk_i) ParamsLegal);

    ack_single_a: assert property (@(posedge clk_i) disable iff (rst_i)
        wake_ack_o |=> !wake_ack_o);

    gated_off_a: assert property (@(posedge clk_i) gated_o |-> !en_o);

endmodule

// File: doc/prim_clock_gate_ctrl.md
PRIM_CLOCK_GATE_CTRL -- requirements
Module: prim_clock_gate_ctrl

Interface
REQ-001 The block SHALL have parameter IdleCycles, default 16: consecutive idle cycles before gating, legal range 1..255.
REQ-002 The block SHALL have parameter WakeCycles, default 2: cycles of enabled clock before the wake acknowledge, legal range 1..15.
REQ-003 The block SHALL have parameter StatsWidth, default 32: width of the gated-cycle counter.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk_i, input, 1 bit: free-running (ungated) clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port busy_i, input, 1 bit: downstream logic has work this cycle.
REQ-008 The block SHALL have port wake_req_i, input, 1 bit: level request to ungate, held until wake_ack_o.
REQ-009 The block SHALL have port test_en_i, input, 1 bit: scan/test override.
REQ-010 The block SHALL have port en_o, output, 1 bit: enable to the clock gating cell, registered.
REQ-011 The block SHALL have port gated_o, output, 1 bit: clock currently gated.
REQ-012 The block SHALL have port wake_ack_o, output, 1 bit: one-cycle pulse completing a wake request.
REQ-013 The block SHALL have port gated_cycles_o, output, StatsWidth bits: cycles spent gated; present only with the macro.

Function
REQ-014 The FSM SHALL have states ACTIVE, GATED and WAKE.
REQ-015 In ACTIVE, the idle counter SHALL increment on each cycle with busy_i=0 and wake_req_i=0, and SHALL clear on any cycle with either input high.
REQ-016 In ACTIVE, when the counter equals IdleCycles-1 on an idle cycle, the FSM SHALL go to GATED on the next edge, and en_o SHALL be 0 and gated_o SHALL be 1 from that edge.
REQ-017 In ACTIVE, wake_req_i=1 SHALL produce wake_ack_o=1 on the next cycle, with no state change.
REQ-018 In GATED, busy_i=1 or wake_req_i=1 SHALL go to WAKE on the next edge, with en_o=1 and gated_o=0 from that edge.
REQ-019 In WAKE, the wake counter SHALL count WakeCycles cycles, then the FSM SHALL go to ACTIVE with the idle counter cleared.
REQ-020 On the transition from WAKE to ACTIVE, wake_ack_o SHALL pulse for that one cycle only if wake_req_i was high during WAKE.
REQ-021 Idle detection SHALL be ignored in WAKE, so no WAKE-to-GATED shortcut exists.
REQ-022 test_en_i=1 SHALL force en_o=1 and gated_o=0 combinationally (en_o = en_q | test_en_i), force the state to ACTIVE, and clear both counters.
REQ-023 wake_ack_o SHALL never be high on two consecutive cycles, and a request held after ack SHALL be re-acknowledged 2 cycles later.
REQ-024 All counters SHALL saturate and never wrap, except gated_cycles_o, which SHALL wrap modulo 2^StatsWidth.

Reset
REQ-025 rst_i=1 at an edge SHALL set state ACTIVE, en_o=1, gated_o=0, wake_ack_o=0, all counters 0, and gated_cycles_o 0.
REQ-026 Reset asserted in GATED or WAKE SHALL restore the enabled clock on the next edge, with no ack issued.

Configuration
REQ-027 With PRIM_CLOCK_GATE_CTRL_STATS_EN defined, gated_cycles_o SHALL exist and increment on every cycle the state is GATED.
REQ-028 Without PRIM_CLOCK_GATE_CTRL_STATS_EN defined, the gated_cycles_o port and its counter SHALL be absent.

Structure
REQ-029 The state enum, the counter width constants (8-bit idle, 4-bit wake) and parameter range checks SHALL live in package prim_clock_gate_ctrl_pkg.
REQ-030 The idle/wake saturating counter SHALL be one sub-module, prim_cg_sat_counter (clear, increment, terminal-count compare), instantiated twice.

Verification
REQ-031 The bench SHALL check: after reset, busy_i=0 for 16 cycles -> en_o falls at edge 16, gated_o=1.
REQ-032 The bench SHALL check: busy_i=0 for 15 cycles, then busy_i=1 for 1 cycle, then 0 -> no gating until 16 further idle cycles.
REQ-033 The bench SHALL check: in GATED, wake_req_i=1 held -> en_o=1 next edge, wake_ack_o single pulse 2 cycles later, state ACTIVE.
REQ-034 The bench SHALL check: in GATED, test_en_i=1 -> en_o=1 same cycle, and after release the idle count restarts from 0.
REQ-035 The bench SHALL check: rst_i=1 mid-WAKE -> en_o=1, wake_ack_o never pulses, gated_cycles_o=0.
REQ-036 The bench SHALL check, with the macro: 100 cycles gated -> gated_cycles_o=100; with StatsWidth=4, 17 cycles -> 1.
